// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle between upstream, subtractor and downstream
import serial_sub_pkg::*;

interface serial_subtractor_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero, overflow
    );
endinterface

// File: rtl/bit_subtractor.sv
// rtl/bit_subtractor.sv - 1-bit full subtractor cell (d = a - b - bin)
module bit_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first through one bit_subtractor cell
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sub_state_t        state, next_state;
    logic [WIDTH-1:0]  a_sr, b_sr;
    logic [WIDTH-2:0]  d_sr;
    logic              brw;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  diff_q;
    logic              borrow_q, zero_q, overflow_q;

    logic              cell_d, cell_bout;
    logic [WIDTH-1:0]  d_shift;

    bit_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Only WIDTH-1 result bits need storing; the last bit comes straight from the cell.
    assign d_shift = {cell_d, d_sr};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start)   next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.a;
                        b_sr <= bus.b;
                        brw  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr <= d_shift[WIDTH-1:1];
                    brw  <= cell_bout;
                    if (cnt != LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        // On the last bit the cell inputs are the operand MSBs.
                        diff_q     <= d_shift;
                        borrow_q   <= cell_bout;
                        zero_q     <= (d_shift == '0);
                        overflow_q <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == SHIFT);
    assign bus.done     = (state == DONE);
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
endmodule
